instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
Instruction fetch stage. It sits directly upstream of the IF/ID pipeline register and owns the fetch PC. It issues word-addressed requests to instruction memory over a req/rdy handshake and presents instr_IF/PC_IF to IF/ID. It also absorbs memory wait states, hazard stalls and branch/jump redirects from later stages.

Parameters:
PC_WIDTH, 22, width of word-addressed PC and of PC_IF / imem_addr
INSTR_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_IF  input  1  hazard unit holds IF and IF/ID (same signal that drives IF/ID stall)
redirect  input  1  taken branch/jump; one-cycle pulse; same cycle as IF/ID flush
redirect_PC  input  PC_WIDTH  target address, valid when redirect=1
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address; stable while imem_req=1 until imem_rdy
imem_rdy  input  1  request complete; imem_rdata valid this cycle
imem_rdata  input  INSTR_WIDTH  fetched word
instr_IF  output  INSTR_WIDTH  instruction to IF/ID; 0 = NOP bubble
PC_IF  output  PC_WIDTH  address of instr_IF plus 1 (link / branch base); 0 with bubble
fetch_busy  output  1  high in WAIT or SQUASH (diagnostic / hazard visibility)

Behaviour:
- Registers: pc (next fetch addr), out_instr/out_pc/out_valid (drive instr_IF/PC_IF), skid_instr/skid_pc, tgt (saved redirect target), 2-bit state.
- Reset: state=FETCH, pc=RESET_PC, out_* =0, out_valid=0, skid=0, tgt=0. imem_req comes high in the first cycle after reset. instr_IF=0, PC_IF=0, fetch_busy=0.
- imem_addr = pc in FETCH/WAIT and tgt-side old address in SQUASH (pc is not updated until squash ends). imem_req=1 in FETCH, WAIT and SQUASH; 0 in HOLD.
- Accept: a response is taken in the cycle imem_req && imem_rdy. Zero-wait memory gives one instruction per cycle.
- Output register can load when stall_IF=0 or out_valid=0.
- FETCH/WAIT, rdy=1, can load: out_instr=rdata, out_pc=pc+1, out_valid=1, pc=pc+1, state=FETCH.
- FETCH/WAIT, rdy=1, cannot load: skid=rdata/pc+1, pc=pc+1, state=HOLD.
- FETCH, rdy=0: state=WAIT. WAIT, rdy=0: stay WAIT.
- When stall_IF=0 and no response is loaded this cycle: out_instr=0, out_pc=0, out_valid=0 (bubble).
- HOLD, stall_IF=0: out_*=skid, out_valid=1, state=FETCH. HOLD, stall_IF=1: hold all.
- While stall_IF=1, out_* hold their values.
- Redirect has priority over stall_IF and over rdy. Same cycle: out_*=0, out_valid=0, skid discarded.
  - FETCH, or WAIT with rdy=1, or HOLD: pc=redirect_PC, state=FETCH, and any same-cycle response is dropped.
  - WAIT with rdy=0: tgt=redirect_PC, state=SQUASH; the address is kept stable.
- SQUASH: hold imem_addr. On rdy, discard rdata, pc=tgt, state=FETCH. A second redirect while in SQUASH overwrites tgt.
- pc+1 wraps modulo 2^PC_WIDTH (0x3FFFFF -> 0).
- Asynchronous reset mid-WAIT aborts immediately: imem_req drops to 0 until the first clock edge after deassert.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_squashed[31:0].
  - perf_fetched increments on each response loaded to out_* or skid.
  - perf_squashed increments on each response dropped by redirect or SQUASH.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, rdy tied 1, rdata = addr: cycle after reset imem_addr=0. Thereafter instr_IF=0,1,2,... with PC_IF=1,2,3,..., one per cycle.
- rdy low 3 cycles on addr 5: fetch_busy=1 and imem_addr=5 stable; instr_IF=0 for those cycles; then instr_IF=5, PC_IF=6.
- stall_IF=1 for 4 cycles with rdy=1: instr_IF/PC_IF frozen; one word goes to skid, then imem_req=0. On release, the skid word appears next, then fetch resumes without loss or duplication.
- redirect to 0x100 while WAIT on addr 8, rdy returns 2 cycles later: imem_addr stays 8, the word is discarded, next imem_addr=0x100, instr_IF=0 until the 0x100 data arrives (perf_squashed=1 if macro on).
- redirect and stall_IF together with rdy=1: instr_IF=0, and the next imem_addr=redirect_PC.
- pc=0x3FFFFF, rdy=1: PC_IF=0 and next imem_addr=0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
// Fetch stage feeding the IF/ID register. Owns the word-addressed fetch PC,
// talks to instruction memory over a req/rdy handshake, absorbs memory wait
// states, hazard stalls (via a one-entry skid buffer) and branch/jump
// redirects (via a squash state when a request is already in flight).
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, adds perf_fetched / perf_squashed 32-bit event counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | request issued at pc, no wait state seen yet
// WAIT   | request at pc outstanding, memory has inserted wait states
// HOLD   | IF stalled with a fetched word parked in skid; no request
// SQUASH | redirect arrived mid-request; finish and drop it, then go to tgt

module instr_fetch_stage #(
    parameter int                  PC_WIDTH    = 22,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_IF,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_PC,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rdy,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_IF,
    output logic [PC_WIDTH-1:0]    PC_IF,
`ifdef FETCH_PERF_CNT_EN
    output logic                   fetch_busy,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_squashed
`else
    output logic                   fetch_busy
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_SQUASH = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic                   started;

    logic [PC_WIDTH-1:0]    pc, pc_nxt, pc_inc;
    logic [PC_WIDTH-1:0]    tgt, tgt_nxt;
    logic [INSTR_WIDTH-1:0] out_instr, out_instr_nxt;
    logic [PC_WIDTH-1:0]    out_pc, out_pc_nxt;
    logic                   out_valid, out_valid_nxt;
    logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_nxt;
    logic [PC_WIDTH-1:0]    skid_pc, skid_pc_nxt;

    logic                   accept;
    logic                   can_load;

    // The address only moves on acceptance or a redirect, so it is simply pc;
    // in SQUASH pc still holds the in-flight address until the drop completes.
    assign imem_addr  = pc;
    assign imem_req   = started && (state != S_HOLD);
    assign accept     = imem_req && imem_rdy;
    assign can_load   = !stall_IF || !out_valid;
    assign pc_inc     = pc + PC_WIDTH'(1);
    assign instr_IF   = out_instr;
    assign PC_IF      = out_pc;
    assign fetch_busy = (state == S_WAIT) || (state == S_SQUASH);

    // Request enable: held low through reset so an aborted fetch is not
    // re-issued until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            tgt        <= '0;
            out_instr  <= '0;
            out_pc     <= '0;
            out_valid  <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            tgt        <= tgt_nxt;
            out_instr  <= out_instr_nxt;
            out_pc     <= out_pc_nxt;
            out_valid  <= out_valid_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    // Next-state and datapath: redirect first, then per-state handling.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        tgt_nxt        = tgt;
        out_instr_nxt  = out_instr;
        out_pc_nxt     = out_pc;
        out_valid_nxt  = out_valid;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;

        if (!started) begin
            // Nothing issued yet; everything holds its reset value.
            state_nxt = state;
        end else if (redirect) begin
            out_instr_nxt  = '0;
            out_pc_nxt     = '0;
            out_valid_nxt  = 1'b0;
            skid_instr_nxt = '0;
            skid_pc_nxt    = '0;
            // A request still waiting on memory cannot have its address
            // changed, so remember the target and drain it first.
            if (((state == S_WAIT) || (state == S_SQUASH)) && !imem_rdy) begin
                tgt_nxt   = redirect_PC;
                state_nxt = S_SQUASH;
            end else begin
                pc_nxt    = redirect_PC;
                state_nxt = S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH, S_WAIT: begin
                    if (imem_rdy) begin
                        pc_nxt = pc_inc;
                        if (can_load) begin
                            out_instr_nxt = imem_rdata;
                            out_pc_nxt    = pc_inc;
                            out_valid_nxt = 1'b1;
                            state_nxt     = S_FETCH;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc_nxt    = pc_inc;
                            state_nxt      = S_HOLD;
                        end
                    end else begin
                        state_nxt = S_WAIT;
                        if (!stall_IF) begin
                            out_instr_nxt = '0;
                            out_pc_nxt    = '0;
                            out_valid_nxt = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_IF) begin
                        out_instr_nxt = skid_instr;
                        out_pc_nxt    = skid_pc;
                        out_valid_nxt = 1'b1;
                        state_nxt     = S_FETCH;
                    end
                end
                S_SQUASH: begin
                    if (imem_rdy) begin
                        pc_nxt    = tgt;
                        state_nxt = S_FETCH;
                    end
                    if (!stall_IF) begin
                        out_instr_nxt = '0;
                        out_pc_nxt    = '0;
                        out_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic load_resp;
    logic drop_resp;

    // A response is kept when it lands in out_* or skid, and lost when a
    // redirect coincides with it or it completes a squashed request.
    assign load_resp = accept && !redirect &&
                       ((state == S_FETCH) || (state == S_WAIT));
    assign drop_resp = accept && (redirect || (state == S_SQUASH));

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (load_resp) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (drop_resp) begin
                perf_squashed <= perf_squashed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios followed by
// randomized stall/redirect/wait-state traffic, compared every cycle against
// a behavioural model of the fetch stage kept in the bench.

module tb_instr_fetch_stage;

    localparam int PW = 22;
    localparam int IW = 32;

    logic          clk;
    logic          rst_n;
    logic          stall_IF;
    logic          redirect;
    logic [PW-1:0] redirect_PC;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_rdy;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] instr_IF;
    logic [PW-1:0] PC_IF;
    logic          fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_squashed;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_stage #(
        .PC_WIDTH   (PW),
        .INSTR_WIDTH(IW),
        .RESET_PC   ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_IF   (stall_IF),
        .redirect   (redirect),
        .redirect_PC(redirect_PC),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .instr_IF   (instr_IF),
        .PC_IF      (PC_IF),
`ifdef FETCH_PERF_CNT_EN
        .fetch_busy   (fetch_busy),
        .perf_fetched (perf_fetched),
        .perf_squashed(perf_squashed)
`else
        .fetch_busy (fetch_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: where fetching is, what IF/ID sees, whether a stalled
    // word is parked, whether the current request has waited, and whether
    // an in-flight request is being thrown away in favour of a redirect.
    logic [PW-1:0] m_pc, m_out_pc, m_skid_pc, m_tgt;
    logic [IW-1:0] m_out_instr, m_skid_instr;
    bit            m_started, m_out_valid, m_skid_full, m_waited, m_squashing;
    logic [31:0]   m_fetched, m_squashed;
    logic [31:0]   salt;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return {10'b0, a} ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = '0;
        m_out_pc     = '0;
        m_skid_pc    = '0;
        m_tgt        = '0;
        m_out_instr  = '0;
        m_skid_instr = '0;
        m_started    = 1'b0;
        m_out_valid  = 1'b0;
        m_skid_full  = 1'b0;
        m_waited     = 1'b0;
        m_squashing  = 1'b0;
        m_fetched    = '0;
        m_squashed   = '0;
    endtask

    task automatic bubble();
        m_out_instr = '0;
        m_out_pc    = '0;
        m_out_valid = 1'b0;
    endtask

    task automatic model_update(input bit stall, input bit redir,
                                input logic [PW-1:0] rpc, input bit rdy);
        logic [PW-1:0] nxt;
        bit            taken;
        if (!m_started) begin
            m_started = 1'b1;
            return;
        end
        taken = !m_skid_full && rdy;
        if (redir) begin
            bubble();
            m_skid_full = 1'b0;
            if (taken) m_squashed++;
            if ((m_squashing || m_waited) && !rdy) begin
                m_tgt       = rpc;
                m_squashing = 1'b1;
                m_waited    = 1'b0;
            end else begin
                m_pc        = rpc;
                m_squashing = 1'b0;
                m_waited    = 1'b0;
            end
        end else if (m_skid_full) begin
            if (!stall) begin
                m_out_instr = m_skid_instr;
                m_out_pc    = m_skid_pc;
                m_out_valid = 1'b1;
                m_skid_full = 1'b0;
            end
        end else if (m_squashing) begin
            if (rdy) begin
                m_pc        = m_tgt;
                m_squashing = 1'b0;
                m_squashed++;
            end
            if (!stall) bubble();
        end else if (rdy) begin
            m_fetched++;
            nxt = m_pc + 1'b1;
            if (!stall || !m_out_valid) begin
                m_out_instr = mem_word(m_pc);
                m_out_pc    = nxt;
                m_out_valid = 1'b1;
            end else begin
                m_skid_instr = mem_word(m_pc);
                m_skid_pc    = nxt;
                m_skid_full  = 1'b1;
            end
            m_pc     = nxt;
            m_waited = 1'b0;
        end else begin
            m_waited = 1'b1;
            if (!stall) bubble();
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare outputs, advance
    // the model for the coming rising edge, and wait for the next falling edge.
    task automatic step(input bit stall, input bit redir,
                        input logic [PW-1:0] rpc, input bit rdy);
        bit exp_req;
        stall_IF    = stall;
        redirect    = redir;
        redirect_PC = rpc;
        imem_rdy    = rdy;
        imem_rdata  = mem_word(m_pc);
        #1;
        exp_req = m_started && !m_skid_full;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("fetch_busy", 32'(fetch_busy), 32'(m_waited || m_squashing));
        check("instr_IF", instr_IF, m_out_instr);
        check("PC_IF", 32'(PC_IF), 32'(m_out_pc));
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_squashed", perf_squashed, m_squashed);
`endif
        model_update(stall, redir, rpc, rdy);
        @(negedge clk);
    endtask

    initial begin
        bit            r_stall, r_redir, r_rdy;
        logic [PW-1:0] r_pc;

        salt        = '0;
        rst_n       = 1'b0;
        stall_IF    = 1'b0;
        redirect    = 1'b0;
        redirect_PC = '0;
        imem_rdy    = 1'b0;
        imem_rdata  = '0;
        model_reset();
        #1;
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset instr_IF", instr_IF, 32'd0);
        check("reset PC_IF", 32'(PC_IF), 32'd0);
        check("reset fetch_busy", 32'(fetch_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait streaming with rdata = addr.
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
        // Three wait states on address 5, then resume.
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        // Stall for four cycles with memory always ready, then release.
        for (int i = 0; i < 4; i++) step(1, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        // Redirect to 0x100 while waiting on address 8.
        step(0, 1, 22'd8, 1);
        step(0, 0, '0, 0);
        step(0, 1, 22'h100, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        // Redirect and stall together with memory ready.
        step(1, 1, 22'h200, 1);
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1);
        // PC wrap at the top of the address space.
        step(0, 1, 22'h3FFFFF, 1);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        // Asynchronous reset while a request is waiting.
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        rst_n = 1'b0;
        #1;
        check("async rst imem_req", 32'(imem_req), 32'd0);
        check("async rst fetch_busy", 32'(fetch_busy), 32'd0);
        check("async rst imem_addr", 32'(imem_addr), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("post rst imem_req", 32'(imem_req), 32'd0);
        model_reset();
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        // Randomized traffic with a non-trivial memory image.
        salt = $urandom;
        for (int i = 0; i < 600; i++) begin
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 9) == 0);
            r_rdy   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) r_pc = 22'h3FFFFC + PW'($urandom_range(0, 3));
            else r_pc = PW'($urandom);
            step(r_stall, r_redir, r_pc, r_rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
